instruction_fetch: RTL

// - Program-counter and fetch stage that sits directly upstream of instruction_mem.
// - After reset it boot-loads a program into instruction_mem over the memory's write port.
// - It then drives pc every cycle and captures inst into the IF/ID pipeline register
//   for the decode stage, with stall, redirect (branch/jump) and halt handling.

---
 rtl/mips_pkg.sv | 14 +
 rtl/instruction_fetch.sv | 118 +++++++++++
 2 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants.
package mips_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] HALT_INST_DEFAULT = 32'hFC00_0000;
  localparam logic [31:0] NOP_INST          = 32'h0000_0000;
  localparam logic [31:0] INST_BYTES        = 32'd4;

endpackage

// File: rtl/instruction_fetch.sv
// Program counter, boot loader into instruction_mem, and the IF/ID pipeline register.
//
// state | meaning
// LOAD  | accepting boot words and writing them into instruction_mem
// RUN   | fetching: advance, stall or redirect each cycle
// HALT  | halt instruction captured; pc frozen until rst
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 256,
  parameter logic [31:0] HALT_INST  = HALT_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic [31:0] imem_add,
  output logic [31:0] imem_data,
  output logic        imem_write,
  output logic [31:0] pc,
  input  logic [31:0] inst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted
);

  localparam logic [31:0] LOAD_WRAP = 32'(IMEM_WORDS) * INST_BYTES;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  load_ptr_q, load_ptr_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  pc4_q, pc4_d;
  logic         valid_q, valid_d;
  logic [31:0]  pc_plus4;

  assign pc_plus4 = pc_q + INST_BYTES;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    load_ptr_d = load_ptr_q;
    inst_d     = inst_q;
    pc4_d      = pc4_q;
    valid_d    = valid_q;
    load_ready = 1'b0;
    imem_write = 1'b0;
    imem_add   = 32'h0;
    imem_data  = 32'h0;

    case (state_q)
      LOAD: begin
        load_ready = 1'b1;
        imem_write = load_valid;
        imem_add   = load_ptr_q;
        imem_data  = load_data;
        pc_d       = RESET_PC;
        valid_d    = 1'b0;
        if (load_valid) begin
          load_ptr_d = (load_ptr_q >= LOAD_WRAP - INST_BYTES) ? 32'h0 : load_ptr_q + INST_BYTES;
          if (load_last) state_d = RUN;
        end
      end
      RUN: begin
        if (redirect) begin
          pc_d    = redirect_pc & ~32'h3;
          inst_d  = NOP_INST;
          valid_d = 1'b0;
        end else if (!stall) begin
          inst_d  = inst;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          // The halt word itself is delivered to decode; only pc stops here.
          if (inst == HALT_INST) state_d = HALT;
          else                   pc_d    = pc_plus4;
        end
      end
      HALT: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD;
      pc_q       <= RESET_PC;
      load_ptr_q <= 32'h0;
      inst_q     <= NOP_INST;
      pc4_q      <= 32'h0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      load_ptr_q <= load_ptr_d;
      inst_q     <= inst_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
    end
  end

  assign pc          = pc_q;
  assign if_id_inst  = inst_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign halted      = (state_q == HALT);

endmodule
